// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE_PRESS,
    STROBE,
    HELD,
    DEBOUNCE_RELEASE
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_EXEC  = 4'd11;
  localparam logic [3:0] KEY_DIV   = 4'd12;
  localparam logic [3:0] KEY_MUL   = 4'd13;
  localparam logic [3:0] KEY_SUB   = 4'd14;
  localparam logic [3:0] KEY_ADD   = 4'd15;

  // Indexed by {row, col}; element 15 is written first.
  localparam logic [15:0][3:0] KEY_MAP = {
    KEY_DIV, KEY_EXEC, 4'd0,    KEY_CLEAR,  // row3: col3..col0
    KEY_MUL, 4'd9,     4'd8,    4'd7,       // row2
    KEY_SUB, 4'd6,     4'd5,    4'd4,       // row1
    KEY_ADD, 4'd3,     4'd2,    4'd1        // row0
  };

  // Index of the lowest-numbered active-low column; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--)
      if (!cols[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle for pulled-up lines).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages to let metastability resolve before use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce, one-cycle keystrobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       keystrobe,
  output logic [3:0] keycode,
  output logic       key_held
);

  // One counter serves both the scan dwell and the debounce windows.
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int CW = (SW > DW) ? SW : DW;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    row, row_nxt;
  logic [1:0]    col, col_nxt;
  logic [3:0]    code_nxt;
  logic [3:0]    col_s;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (col_s)
  );

  // State, counters, latched key position and output code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      cnt     <= '0;
      row     <= '0;
      col     <= '0;
      keycode <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      keycode <= code_nxt;
    end
  end

  // Next-state logic; row stays frozen on the latched row outside SCAN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    col_nxt   = col;
    code_nxt  = keycode;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (col_s != 4'hF) begin
            col_nxt   = lowest_low(col_s);
            state_nxt = DEBOUNCE_PRESS;
          end else begin
            row_nxt = row + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DEBOUNCE_PRESS: begin
        if (col_s[col]) begin
          state_nxt = SCAN;
          row_nxt   = row + 2'd1;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = STROBE;
          cnt_nxt   = '0;
          code_nxt  = KEY_MAP[{row, col}];
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STROBE: state_nxt = HELD;
      HELD: begin
        // Only the latched column matters here; other keys are ignored.
        if (col_s[col]) begin
          state_nxt = DEBOUNCE_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DEBOUNCE_RELEASE: begin
        if (!col_s[col]) begin
          state_nxt = HELD;
        end else if (cnt == DEB_LAST) begin
          state_nxt = SCAN;
          row_nxt   = row + 2'd1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign row_n     = ~(4'b0001 << row);
  assign keystrobe = (state == STROBE);
  assign key_held  = (state == STROBE) || (state == HELD) || (state == DEBOUNCE_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model, strobe monitor, directed and random key sequences.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  // Earliest/latest press-to-strobe latency: 2 sync + dwell remaining + DEBOUNCE + 1.
  localparam int LAT_MIN  = 2 + 1 + DEBOUNCE;
  localparam int LAT_MAX  = LAT_MIN + 4 * SCAN_DIV - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       keystrobe;
  logic [3:0] keycode;
  logic       key_held;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .keystrobe (keystrobe),
    .keycode   (keycode),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to its row.
  logic [3:0] pressed [4];
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~pressed[r];
  end

  int ref_map [4][4] = '{'{1, 2, 3, 15}, '{4, 5, 6, 14}, '{7, 8, 9, 13}, '{10, 0, 11, 12}};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q [$];
  int got_code [$];
  int got_cyc [$];
  int dbl = 0, kc_bad = 0, nohold = 0;
  int last_code = 0;
  logic prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every strobe and watches output invariants.
  always @(negedge clk) begin
    if (reset) begin
      last_code   = 0;
      prev_strobe = 1'b0;
    end else begin
      if (keystrobe) begin
        got_code.push_back(int'(keycode));
        got_cyc.push_back(cyc);
        if (prev_strobe) dbl++;
        if (!key_held) nohold++;
        last_code = int'(keycode);
      end else if (int'(keycode) != last_code) begin
        kc_bad++;
      end
      prev_strobe = keystrobe;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row_n"}, 32'(row_n), 32'(4'b1110));
    chk({tag, "_strobe"}, 32'(keystrobe), 0);
    chk({tag, "_keycode"}, 32'(keycode), 0);
    chk({tag, "_held"}, 32'(key_held), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    step(2);
    reset = 1'b0;
    got_code.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 32'(got_code.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_code.size() && i < exp_q.size(); i++)
      chk({tag, "_code"}, 32'(got_code[i]), 32'(exp_q[i]));
    got_code.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int rel);
    pressed[r][c] = 1'b1;
    exp_q.push_back(ref_map[r][c]);
    step(hold);
    pressed[r][c] = 1'b0;
    step(rel);
  endtask

  initial begin
    int pc, lat, r, c;
    for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
    step(1);
    do_reset("rst0");

    // Idle scan: each row driven for SCAN_DIV cycles in turn.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] e;
      e = 4'b1111 ^ (4'b0001 << ((k / SCAN_DIV) % 4));
      chk("idle_row", 32'(row_n), 32'(e));
      step(1);
    end
    check_seq("idle");

    // Single key (row1,col2) with latency and release-hold window.
    pressed[1][2] = 1'b1;
    exp_q.push_back(ref_map[1][2]);
    pc = cyc;
    step(30);
    chk("held_before_release", 32'(key_held), 1);
    pressed[1][2] = 1'b0;
    step(DEBOUNCE);
    chk("held_in_release_debounce", 32'(key_held), 1);
    step(4);
    chk("released", 32'(key_held), 0);
    step(8);
    lat = (got_cyc.size() > 0) ? got_cyc[0] - pc : -1;
    chk("latency_in_range", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
    chk("keycode_after_release", 32'(keycode), 6);
    check_seq("k6");

    // Press bounce on (row0,col3) then steady.
    pressed[0][3] = 1'b1; step(3);
    pressed[0][3] = 1'b0; step(2);
    chk("bounce_no_strobe", 32'(got_code.size()), 0);
    pressed[0][3] = 1'b1;
    pc = cyc;
    exp_q.push_back(15);
    step(30);
    pressed[0][3] = 1'b0;
    step(20);
    lat = (got_cyc.size() > 0) ? got_cyc[0] - pc : -1;
    chk("bounce_latency", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
    check_seq("k15");

    // Two keys in row3 together, then release bounce on the accepted one.
    pressed[3][0] = 1'b1;
    pressed[3][2] = 1'b1;
    exp_q.push_back(10);
    step(30);
    pressed[3][0] = 1'b0;
    pressed[3][2] = 1'b0;
    step(4);
    pressed[3][0] = 1'b1; step(3);
    chk("held_through_release_bounce", 32'(key_held), 1);
    pressed[3][0] = 1'b0;
    step(20);
    chk("held_clear_after_bounce", 32'(key_held), 0);
    check_seq("k10");

    // Reset during press debounce of (row2,col1); key stays down.
    do_reset("rst1");
    pressed[2][1] = 1'b1;
    step(15);
    chk("no_strobe_before_reset", 32'(got_code.size()), 0);
    do_reset("rst_mid");
    exp_q.push_back(8);
    step(40);
    pressed[2][1] = 1'b0;
    step(20);
    check_seq("k8");

    // Calculator sequence 1, +, 2, =.
    press_key(0, 0, 30, 20);
    press_key(0, 3, 30, 20);
    press_key(0, 1, 30, 20);
    press_key(3, 2, 30, 20);
    check_seq("seq");

    // Random keys, some preceded by a short press bounce.
    for (int n = 0; n < 12; n++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) begin
        pressed[r][c] = 1'b1; step(int'($urandom_range(4, 1)));
        pressed[r][c] = 1'b0; step(2);
      end
      press_key(r, c, int'($urandom_range(40, 30)), int'($urandom_range(28, 20)));
    end
    check_seq("rand");

    chk("no_back_to_back_strobe", 32'(dbl), 0);
    chk("keycode_stable_between_strobes", 32'(kc_bad), 0);
    chk("held_with_strobe", 32'(nohold), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, meaning clock cycles each row is driven before its columns are sampled (minimum 4).
REQ-002 Parameter DEBOUNCE, default 50000, meaning consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port col_n  input  4  matrix column sense lines, active-low (pulled up externally), asynchronous to clk.
REQ-006 Port row_n  output  4  matrix row drive, active-low, one-hot-low.
REQ-007 Port keystrobe  output  1  one-cycle pulse per accepted key press.
REQ-008 Port keycode  output  4  code of the most recently accepted key, valid from the keystrobe cycle until the next keystrobe.
REQ-009 Port key_held  output  1  high from keystrobe until release debounce completes.

Function
REQ-010 col_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 Key map (row,col) -> keycode SHALL be: row0 1,2,3,15; row1 4,5,6,14; row2 7,8,9,13; row3 10,0,11,12 (10 clear, 11 execute, 15 +, 14 -, 13 *, 12 /).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE_PRESS, STROBE, HELD, DEBOUNCE_RELEASE.
REQ-013 SCAN: row_n drives one row low; dwell counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 sampled columns are checked; none low -> next row (3 wraps to 0), counter cleared.
REQ-014 SCAN with any sampled column low SHALL latch row and lowest-index low column, go DEBOUNCE_PRESS, and freeze row_n.
REQ-015 DEBOUNCE_PRESS SHALL count cycles with the latched column low; latched column high -> SCAN advancing to next row, no strobe.
REQ-016 DEBOUNCE_PRESS reaching DEBOUNCE cycles SHALL go STROBE.
REQ-017 STROBE SHALL last exactly one cycle: keystrobe=1, keycode updated in the same cycle, key_held=1; next state HELD.
REQ-018 HELD: latched column high -> DEBOUNCE_RELEASE with counter cleared; other columns ignored (no rollover, no auto-repeat).
REQ-019 DEBOUNCE_RELEASE: latched column low -> back to HELD; DEBOUNCE consecutive high cycles -> SCAN on next row, key_held=0.
REQ-020 Simultaneous presses in one row SHALL yield only the lowest column; presses in other rows are ignored until return to SCAN.
REQ-021 keystrobe SHALL never be high on two consecutive cycles; at most one strobe per press-release cycle.
REQ-022 Press-to-strobe latency SHALL be 2 (sync) + remaining dwell + DEBOUNCE + 1 cycles.

Reset
REQ-023 Reset asserted SHALL immediately force: state SCAN, row_n=4'b1110, keystrobe=0, keycode=0, key_held=0, all counters and synchronizer flops 0/idle (sync flops to 1).
REQ-024 Reset mid-debounce or mid-hold SHALL abandon the key with no strobe; a key still held after reset is accepted again via full debounce.

Structure
REQ-025 Package keypad_pkg SHALL hold the FSM state typedef, the 16-entry key-map constant, and named keycode constants (KEY_CLEAR=10, KEY_EXEC=11, KEY_DIV=12, KEY_MUL=13, KEY_SUB=14, KEY_ADD=15).
REQ-026 The 2-flop synchronizer SHALL be one sub-module, sync_2ff, parameterised by width (4 here).
REQ-027 Output keystrobe/keycode SHALL feed the keypad handler directly with no further registering.

Verification (SCAN_DIV=4, DEBOUNCE=8)
REQ-028 No keys, 40 cycles after reset -> row_n cycles 1110,1101,1011,0111 every 4 cycles, keystrobe never 1.
REQ-029 Hold (row1,col2) 30 cycles then release 20 -> exactly one keystrobe, keycode=6, key_held high until 8 cycles after release.
REQ-030 Bounce (row0,col3) low 3 cycles, high 2, then low steady -> single keystrobe, keycode=15, no strobe during bounce.
REQ-031 Press (row3,col0) and (row3,col2) together -> keycode=10 only; release-bounce of 3 cycles mid-DEBOUNCE_RELEASE -> no second strobe.
REQ-032 Press (row2,col1), assert reset during DEBOUNCE_PRESS, keep key held -> outputs at reset values immediately, later one keystrobe with keycode=8.
REQ-033 Sequence 1,+,2,= -> keycodes 1,15,2,11 in order, one strobe each.
